// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
// PS2_SCANCODE_DECODE_EN widens FIFO entries to {ext,brk,code}.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_e;

   localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_entry_t;

`ifdef PS2_SCANCODE_DECODE_EN
   localparam int PS2_W = 10;
`else
   localparam int PS2_W = 8;
`endif

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with separate level count.
// A push while full only lands if a pop frees a slot that cycle.
module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [W-1:0]           push_data,
   input  logic                   pop,
   output logic [W-1:0]           pop_data,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_push, do_pop;

   assign full     = (level == LW'(DEPTH));
   assign empty    = (level == '0);
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: sync, clock deglitch, deframe, watchdog, byte FIFO.
// Define PS2_SCANCODE_DECODE_EN to fold E0/F0 prefixes into entries.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_LEN    = 4,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ps2_clk,
   input  logic                   ps2_data,
   output logic [PS2_W-1:0]       rd_data,
   output logic                   rd_valid,
   input  logic                   rd_pop,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   output logic                   parity_err,
   output logic                   frame_err,
   input  logic                   clr_err
);
   localparam int FW = $clog2(FILT_LEN + 1);

   logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
   logic                   clk_s, dat_s;
   logic                   filt, filt_prev, strobe;
   logic [FW-1:0]          filt_cnt;

   ps2_state_e       state_q, state_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       sh_q, sh_d;
   logic             par_q, par_d;
   logic [15:0]      wd_q, wd_d;
   logic             par_set, frm_set, good, abort;
   logic             push_q, push_d;
   logic [PS2_W-1:0] pdat_q, pdat_d;
   logic             full, empty, ovf_set;
`ifdef PS2_SCANCODE_DECODE_EN
   logic             ext_q, ext_d, brk_q, brk_d;
   ps2_entry_t       ent;
`endif

   assign clk_s  = clk_sync[SYNC_STAGES-1];
   assign dat_s  = dat_sync[SYNC_STAGES-1];
   assign strobe = filt_prev & ~filt;

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync  <= '1;
         dat_sync  <= '1;
         filt      <= 1'b1;
         filt_prev <= 1'b1;
         filt_cnt  <= '0;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         dat_sync  <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
         filt_prev <= filt;
         if (clk_s != filt) begin
            if (filt_cnt == FW'(FILT_LEN - 1)) begin
               filt     <= clk_s;
               filt_cnt <= '0;
            end else begin
               filt_cnt <= filt_cnt + FW'(1);
            end
         end else begin
            filt_cnt <= '0;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      par_d   = par_q;
      par_set = 1'b0;
      frm_set = 1'b0;
      good    = 1'b0;
      abort   = 1'b0;
      if (strobe) begin
         unique case (state_q)
            IDLE: begin
               if (!dat_s) begin
                  state_d = DATA;
                  bit_d   = 3'd0;
               end
            end
            DATA: begin
               sh_d  = {dat_s, sh_q[7:1]};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = PARITY;
            end
            PARITY: begin
               par_d   = dat_s;
               state_d = STOP;
            end
            STOP: begin
               state_d = IDLE;
               par_set = !(^{sh_q, par_q});
               frm_set = !dat_s;
               good    = dat_s & (^{sh_q, par_q});
            end
            default: state_d = IDLE;
         endcase
      end else if (state_q != IDLE && wd_q == 16'(TIMEOUT_CYC - 1)) begin
         abort   = 1'b1;
         frm_set = 1'b1;
         state_d = IDLE;
      end
      if (state_q == IDLE || strobe || abort) wd_d = '0;
      else                                    wd_d = wd_q + 16'd1;
   end

`ifdef PS2_SCANCODE_DECODE_EN
   // Prefix bytes only arm flags; the next plain byte carries them.
   always_comb begin
      ext_d  = ext_q;
      brk_d  = brk_q;
      push_d = 1'b0;
      ent    = '{ext: ext_q, brk: brk_q, code: sh_q};
      pdat_d = ent;
      if (good) begin
         if (sh_q == PS2_PREFIX_EXT) begin
            ext_d = 1'b1;
         end else if (sh_q == PS2_PREFIX_BRK) begin
            brk_d = 1'b1;
         end else begin
            push_d = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
         end
      end
      if (abort) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ext_q <= 1'b0;
         brk_q <= 1'b0;
      end else begin
         ext_q <= ext_d;
         brk_q <= brk_d;
      end
   end
`else
   always_comb begin
      push_d = good;
      pdat_d = sh_q;
   end
`endif

   assign ovf_set = push_q & full & ~rd_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         bit_q      <= '0;
         sh_q       <= '0;
         par_q      <= 1'b0;
         wd_q       <= '0;
         push_q     <= 1'b0;
         pdat_q     <= '0;
         overflow   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_q      <= bit_d;
         sh_q       <= sh_d;
         par_q      <= par_d;
         wd_q       <= wd_d;
         push_q     <= push_d;
         pdat_q     <= pdat_d;
         overflow   <= (overflow & ~clr_err) | ovf_set;
         parity_err <= (parity_err & ~clr_err) | par_set;
         frame_err  <= (frame_err & ~clr_err) | frm_set;
      end
   end

   sync_fifo #(
      .W     (PS2_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_q),
      .push_data (pdat_q),
      .pop       (rd_pop),
      .pop_data  (rd_data),
      .level     (level),
      .full      (full),
      .empty     (empty)
   );

   assign rd_valid = ~empty;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: frame vectors, FIFO corners, watchdog.
// Decode checks run when PS2_SCANCODE_DECODE_EN is defined.
module tb_ps2_rx_fifo;
   import ps2_pkg::*;

   localparam int DEPTH = 4;
   localparam int SYNC  = 2;
   localparam int FILT  = 4;
   localparam int TMO   = 300;
   localparam int HALF  = 20;
   localparam int LAT   = SYNC + FILT + 2;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             ps2_clk = 1'b1;
   logic             ps2_data = 1'b1;
   logic             rd_pop = 1'b0;
   logic             clr_err = 1'b0;
   logic [PS2_W-1:0] rd_data;
   logic             rd_valid;
   logic [LW-1:0]    level;
   logic             overflow, parity_err, frame_err;

   int               checks = 0;
   int               failures = 0;
   int               lat;
   logic [PS2_W-1:0] exp_q [$];
   bit               m_ext = 0;
   bit               m_brk = 0;

   typedef struct {
      logic [7:0] data;
      bit         pflip;
      bit         stop;
      bit         e_par;
      bit         e_frm;
   } vec_t;
   vec_t vecs [6];

   always #5 clk = ~clk;

   ps2_rx_fifo #(
      .DEPTH       (DEPTH),
      .SYNC_STAGES (SYNC),
      .FILT_LEN    (FILT),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_pop     (rd_pop),
      .level      (level),
      .overflow   (overflow),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .clr_err    (clr_err)
   );

   initial begin : guard
      repeat (100000) @(posedge clk);
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic send_raw(input logic [10:0] f, input int n,
                           input int pop_at, output int l);
      bit was_v;
      l = 0;
      for (int i = 0; i < n; i++) begin
         ps2_data = f[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         was_v = rd_valid;
         for (int k = 1; k <= HALF; k++) begin
            @(negedge clk);
            if (i == n - 1 && pop_at != 0) begin
               if (k == pop_at)          rd_pop = 1'b1;
               else if (k == pop_at + 1) rd_pop = 1'b0;
            end
            if (i == n - 1 && !was_v && rd_valid && l == 0) l = k;
         end
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit pflip,
                             input bit stop, input int pop_at,
                             output int l);
      logic [10:0]      f;
      logic [PS2_W-1:0] e;
      bit               push;
      f    = {stop, (~^b) ^ pflip, b, 1'b0};
      push = 0;
      e    = '0;
      if (stop && !pflip) begin
`ifdef PS2_SCANCODE_DECODE_EN
         if (b == 8'hE0)      m_ext = 1;
         else if (b == 8'hF0) m_brk = 1;
         else begin
            e = {m_ext, m_brk, b};
            m_ext = 0;
            m_brk = 0;
            push = 1;
         end
`else
         e = b;
         push = 1;
`endif
      end
      if (push) begin
         if (pop_at != 0 && exp_q.size() > 0) void'(exp_q.pop_front());
         if (exp_q.size() < DEPTH) exp_q.push_back(e);
      end
      send_raw(f, 11, pop_at, l);
   endtask

   task automatic pop_chk(input string nm);
      logic [PS2_W-1:0] e;
      e = exp_q.pop_front();
      chk({nm, "_valid"}, rd_valid, 1);
      chk(nm, rd_data, e);
      rd_pop = 1'b1;
      @(negedge clk);
      rd_pop = 1'b0;
   endtask

   task automatic drain(input string nm);
      while (exp_q.size() > 0) pop_chk(nm);
      chk({nm, "_empty"}, rd_valid, 0);
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      vecs[0] = '{8'h1C, 0, 1, 0, 0};
      vecs[1] = '{8'h1C, 1, 1, 1, 0};
      vecs[2] = '{8'hA5, 0, 0, 0, 1};
      vecs[3] = '{8'h3C, 1, 0, 1, 1};
      vecs[4] = '{8'hFF, 0, 1, 0, 0};
      vecs[5] = '{8'h00, 0, 1, 0, 0};

      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", rd_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_par", parity_err, 0);
      chk("rst_frm", frame_err, 0);

      send_frame(8'h1C, 0, 1, 0, lat);
      chk("latency", lat, LAT);
      chk("one_level", level, 1);
      chk("one_data", rd_data, 'h1C);
      pop_chk("one_pop");
      chk("one_level0", level, 0);
      chk("one_valid0", rd_valid, 0);

      for (int i = 0; i < 6; i++) begin
         send_frame(vecs[i].data, vecs[i].pflip, vecs[i].stop, 0, lat);
         chk($sformatf("v%0d_par", i), parity_err, vecs[i].e_par);
         chk($sformatf("v%0d_frm", i), frame_err, vecs[i].e_frm);
         chk($sformatf("v%0d_lvl", i), level, exp_q.size());
         drain($sformatf("v%0d_pop", i));
         pulse_clr();
         chk($sformatf("v%0d_clr_par", i), parity_err, 0);
         chk($sformatf("v%0d_clr_frm", i), frame_err, 0);
      end

      for (int i = 1; i <= 5; i++) send_frame(8'(i), 0, 1, 0, lat);
      chk("ovf_level", level, DEPTH);
      chk("ovf_head", rd_data, 'h01);
      chk("ovf_flag", overflow, 1);
      drain("ovf_pop");
      chk("ovf_sticky", overflow, 1);
      pulse_clr();
      chk("ovf_clr", overflow, 0);

      for (int i = 1; i <= 4; i++) send_frame(8'(i), 0, 1, 0, lat);
      chk("fp_level_pre", level, DEPTH);
      chk("fp_head_pre", rd_data, 'h01);
      send_frame(8'h05, 0, 1, 7, lat);
      chk("fp_level", level, DEPTH);
      chk("fp_ovf", overflow, 0);
      chk("fp_head", rd_data, 'h02);
      drain("fp_pop");

      send_raw(11'b000_0000_0100, 4, 0, lat);
      chk("wd_early", frame_err, 0);
      repeat (TMO + 50) @(negedge clk);
      chk("wd_frm", frame_err, 1);
      chk("wd_par", parity_err, 0);
      chk("wd_level", level, 0);
      pulse_clr();
      chk("wd_clr", frame_err, 0);
      send_frame(8'h2A, 0, 1, 0, lat);
      chk("wd_next_lvl", level, 1);
      chk("wd_next_frm", frame_err, 0);
      chk("wd_next_data", rd_data, 'h2A);
      drain("wd_next_pop");

      send_raw(11'b000_0000_0110, 4, 0, lat);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (TMO + 50) @(negedge clk);
      chk("rstmid_frm", frame_err, 0);
      chk("rstmid_par", parity_err, 0);
      send_frame(8'h5B, 0, 1, 0, lat);
      chk("rstmid_next", rd_data, 'h5B);
      drain("rstmid_pop");

`ifdef PS2_SCANCODE_DECODE_EN
      send_frame(8'hE0, 0, 1, 0, lat);
      send_frame(8'hF0, 0, 1, 0, lat);
      send_frame(8'h75, 0, 1, 0, lat);
      send_frame(8'h1C, 0, 1, 0, lat);
      chk("dec_level", level, 2);
      chk("dec_e0", rd_data, 'h375);
      pop_chk("dec_pop0");
      chk("dec_e1", rd_data, 'h01C);
      pop_chk("dec_pop1");
      chk("dec_level0", level, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised successor to the single-channel PS/2 keyboard receiver. Oversamples ps2_clk/ps2_data in the system clock domain, deglitches the clock, and deframes 11-bit PS/2 frames with an explicit state machine. Valid bytes go into a DEPTH-entry FIFO with a valid/pop handshake. Adds a frame watchdog, sticky error/overflow flags with clear, a fill level, and optional scan-code prefix decoding. Sits between the PS/2 pins and the keyboard/ASCII consumer.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..256.
SYNC_STAGES, 2, input synchroniser flops for ps2_clk and ps2_data; minimum 2.
FILT_LEN, 4, consecutive identical synchronised ps2_clk samples needed to change the filtered clock; minimum 1.
TIMEOUT_CYC, 50000, idle system-clock cycles mid-frame before abort; 16-bit counter.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ps2_clk  in  1  raw PS/2 clock pin, asynchronous
ps2_data  in  1  raw PS/2 data pin, asynchronous
rd_data  out  W  FIFO head; W=8, or W=10 with decode enabled ({ext,brk,code})
rd_valid  out  1  FIFO non-empty
rd_pop  in  1  consume head when rd_valid=1; ignored when empty
level  out  $clog2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: a good byte was dropped because the FIFO was full
parity_err  out  1  sticky: a frame failed odd parity
frame_err  out  1  sticky: bad start/stop bit, or watchdog abort
clr_err  in  1  clears all three sticky flags next cycle; a new set in the same cycle wins

Behaviour:
- Reset (sync, rst=1): FSM to IDLE, pointers/level=0, rd_valid=0, all flags=0, filtered clock=1, watchdog=0, synchronisers=1. FIFO storage is not cleared.
- Sampling: the filtered ps2_clk toggles only after FILT_LEN equal synchronised samples. A sample strobe fires on the filtered 1->0 transition and uses the synchronised ps2_data of that cycle.
- FSM, advancing on each sample strobe:
  - IDLE: data=0 -> DATA with bit counter 0; data=1 is ignored.
  - DATA: shift in LSB first; after the 8th bit -> PARITY.
  - PARITY: latch the parity bit -> STOP.
  - STOP: then -> IDLE.
- Frame checks in STOP: good frame = stop=1 and odd parity over data+parity.
  - Parity fail sets parity_err.
  - Stop=0 sets frame_err.
  - A frame with both faults sets both flags.
  - Bad frames are dropped.
- Watchdog: counts cycles without a strobe while FSM != IDLE. On reaching TIMEOUT_CYC: FSM -> IDLE, frame_err=1, partial byte discarded.
- Push: a good byte is written the cycle after the STOP strobe.
- Latency: stop-bit strobe to rd_valid=1 is 2 clk cycles when the FIFO was empty.
- Full: level==DEPTH. A push while full and without a same-cycle pop is dropped and sets overflow; FIFO contents are unchanged (no overwrite).
- Simultaneous push+pop when full: both succeed, level unchanged.
- Simultaneous push+pop when empty: the pop is ignored, the push succeeds.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level is tracked separately.
- rd_data always shows the FIFO head; it is undefined when rd_valid=0.
- rst mid-frame aborts the frame without setting any error flag.

Optional Feature:
PS2_SCANCODE_DECODE_EN.
- Defined:
  - Good byte 0xE0 sets a pending-ext bit; 0xF0 sets a pending-brk bit. Neither is pushed.
  - Any other byte pushes {ext,brk,code} and clears both pending bits.
  - Pending bits clear on rst and on watchdog abort.
  - rd_data width is 10.
- Undefined: every good byte is pushed raw; rd_data width is 8.

Decomposition:
- Package ps2_pkg holds:
  - FSM state enum (IDLE, DATA, PARITY, STOP)
  - PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BRK=8'hF0
  - the decoded-entry struct {ext,brk,code}
- Sub-module: sync_fifo (parametrised width/depth, push/pop/level/full/empty), instantiated once.
- Synchroniser, filter, FSM and watchdog stay in the top module.

Test Plan:
- Single frame 0x1C, parity=0, stop=1 -> rd_valid=1 two cycles after the stop strobe; rd_data=0x1C; level=1; pop -> level=0, rd_valid=0.
- Frame 0x1C with parity=1 -> parity_err=1, no push; clr_err -> parity_err=0.
- DEPTH=4: five good frames 0x01..0x05 with no pops -> level=4, head=0x01, overflow=1; 0x05 lost.
- DEPTH=4 full; pop asserted in the cycle of the 5th push -> level stays 4; order 0x02..0x05; overflow=0.
- Start bit plus 3 data bits, then idle for TIMEOUT_CYC cycles -> frame_err=1, FSM back in IDLE; a following frame 0x2A is received correctly.
- Decode enabled: frames E0,F0,75 then 1C -> entries 10'b11_0111_0101 then 10'b00_0001_1100; level=2.
